// File: rtl/mem_port_arbiter.sv
// Shares one in-order req/gnt/rvalid memory port between instruction fetch and
// the LSU, routing responses back through a small ID FIFO.
module mem_port_arbiter #(
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned STARVE_LIMIT    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_req_i,
  input  logic [31:0] instr_addr_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  output logic [31:0] instr_rdata_o,
  output logic        instr_err_o,
  input  logic        instr_flush_i,
  input  logic        data_req_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_err_i,
  output logic        busy_o,
  output logic        protocol_err_o
);

  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned STV_W = $clog2(STARVE_LIMIT + 1);

  typedef enum logic {OWN_INSTR = 1'b0, OWN_DATA = 1'b1} owner_e;
  typedef enum logic [1:0] {LK_IDLE, LK_INSTR, LK_DATA} lock_e;

  lock_e              lock_q, lock_d;
  logic [STV_W-1:0]   starve_q, starve_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [PTR_W-1:0]   wptr_q, rptr_q;
  owner_e             id_q   [MAX_OUTSTANDING];
  logic               drop_q [MAX_OUTSTANDING];
  logic               protocol_err_q;

  owner_e owner;
  logic   owner_valid, req, gnt, push, pop, not_full;
  owner_e head_id;
  logic   head_drop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
  endfunction

  assign not_full  = (count_q < CNT_W'(MAX_OUTSTANDING));
  assign head_id   = id_q[rptr_q];
  assign head_drop = drop_q[rptr_q];
  assign pop       = mem_rvalid_i & (count_q != '0);

  // Owner selection, lock tracking and starvation counter update
  always_comb begin
    owner       = OWN_DATA;
    owner_valid = 1'b0;
    lock_d      = lock_q;
    starve_d    = starve_q;
    case (lock_q)
      LK_INSTR: begin
        owner       = OWN_INSTR;
        owner_valid = instr_req_i & ~instr_flush_i;
      end
      LK_DATA: begin
        owner       = OWN_DATA;
        owner_valid = data_req_i;
      end
      default: begin
        if (instr_req_i & ~instr_flush_i &
            ((starve_q >= STV_W'(STARVE_LIMIT)) | ~data_req_i)) begin
          owner       = OWN_INSTR;
          owner_valid = 1'b1;
        end else if (data_req_i) begin
          owner       = OWN_DATA;
          owner_valid = 1'b1;
        end
      end
    endcase
    req  = owner_valid & not_full;
    gnt  = req & mem_gnt_i;
    push = gnt;
    if (req & ~mem_gnt_i) begin
      lock_d = (owner == OWN_INSTR) ? LK_INSTR : LK_DATA;
    end else if (gnt) begin
      lock_d = LK_IDLE;
    end
    if ((gnt & (owner == OWN_INSTR)) | ~instr_req_i) begin
      starve_d = '0;
    end else if (gnt & (owner == OWN_DATA) & (starve_q < STV_W'(STARVE_LIMIT))) begin
      starve_d = starve_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_q         <= LK_IDLE;
      starve_q       <= '0;
      count_q        <= '0;
      wptr_q         <= '0;
      rptr_q         <= '0;
      protocol_err_q <= 1'b0;
    end else begin
      lock_q         <= lock_d;
      starve_q       <= starve_d;
      count_q        <= count_d;
      protocol_err_q <= protocol_err_q | (mem_rvalid_i & (count_q == '0));
      if (push) wptr_q <= ptr_inc(wptr_q);
      if (pop)  rptr_q <= ptr_inc(rptr_q);
    end
  end

  // FIFO storage; a flush marks every fetch entry so its response is swallowed
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(MAX_OUTSTANDING); i++) begin
        id_q[i]   <= OWN_INSTR;
        drop_q[i] <= 1'b0;
      end
    end else begin
      if (instr_flush_i) begin
        for (int i = 0; i < int'(MAX_OUTSTANDING); i++) begin
          if (id_q[i] == OWN_INSTR) drop_q[i] <= 1'b1;
        end
      end
      if (push) begin
        id_q[wptr_q]   <= owner;
        drop_q[wptr_q] <= 1'b0;
      end
    end
  end

  // Combinational outputs are forced low while reset is asserted
  always_comb begin
    mem_req_o      = req & ~rst;
    instr_gnt_o    = gnt & (owner == OWN_INSTR) & ~rst;
    data_gnt_o     = gnt & (owner == OWN_DATA) & ~rst;
    mem_we_o       = 1'b0;
    mem_be_o       = 4'h0;
    mem_addr_o     = 32'h0;
    mem_wdata_o    = 32'h0;
    if (owner_valid & ~rst) begin
      if (owner == OWN_INSTR) begin
        mem_be_o   = 4'hF;
        mem_addr_o = instr_addr_i;
      end else begin
        mem_we_o    = data_we_i;
        mem_be_o    = data_be_i;
        mem_addr_o  = data_addr_i;
        mem_wdata_o = data_wdata_i;
      end
    end
    instr_rvalid_o = pop & (head_id == OWN_INSTR) & ~head_drop & ~instr_flush_i & ~rst;
    data_rvalid_o  = pop & (head_id == OWN_DATA) & ~rst;
    instr_rdata_o  = instr_rvalid_o ? mem_rdata_i : 32'h0;
    instr_err_o    = instr_rvalid_o & mem_err_i;
    data_rdata_o   = data_rvalid_o ? mem_rdata_i : 32'h0;
    data_err_o     = data_rvalid_o & mem_err_i;
  end

  assign busy_o         = (count_q != '0);
  assign protocol_err_o = protocol_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (MAX_OUTSTANDING=2, STARVE_LIMIT=4).
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_req_i, instr_flush_i, data_req_i, data_we_i;
  logic [31:0] instr_addr_i, data_addr_i, data_wdata_i, mem_rdata_i;
  logic [3:0]  data_be_i;
  logic        mem_gnt_i, mem_rvalid_i, mem_err_i;
  logic        instr_gnt_o, instr_rvalid_o, instr_err_o;
  logic [31:0] instr_rdata_o, data_rdata_o, mem_addr_o, mem_wdata_o;
  logic        data_gnt_o, data_rvalid_o, data_err_o;
  logic        mem_req_o, mem_we_o, busy_o, protocol_err_o;
  logic [3:0]  mem_be_o;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.MAX_OUTSTANDING(2), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i), .instr_gnt_o(instr_gnt_o),
    .instr_rvalid_o(instr_rvalid_o), .instr_rdata_o(instr_rdata_o), .instr_err_o(instr_err_o),
    .instr_flush_i(instr_flush_i),
    .data_req_i(data_req_i), .data_we_i(data_we_i), .data_be_i(data_be_i),
    .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i), .data_gnt_o(data_gnt_o),
    .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o), .data_err_o(data_err_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .mem_err_i(mem_err_i),
    .busy_o(busy_o), .protocol_err_o(protocol_err_o)
  );

  task automatic idle_inputs();
    instr_req_i = 0; instr_addr_i = 0; instr_flush_i = 0;
    data_req_i = 0; data_we_i = 0; data_be_i = 0; data_addr_i = 0; data_wdata_i = 0;
    mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = 0; mem_err_i = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    total++; if (mem_req_o !== 1'b0) $display("FAIL rst_mem_req got %0h exp 0", mem_req_o); else passed++;
    total++; if (busy_o !== 1'b0) $display("FAIL rst_busy got %0h exp 0", busy_o); else passed++;
    total++; if (protocol_err_o !== 1'b0) $display("FAIL rst_perr got %0h exp 0", protocol_err_o); else passed++;
    total++; if ({instr_gnt_o, data_gnt_o, instr_rvalid_o, data_rvalid_o} !== 4'b0)
      $display("FAIL rst_handshake got %b exp 0000", {instr_gnt_o, data_gnt_o, instr_rvalid_o, data_rvalid_o}); else passed++;
    rst = 0;
    tick();
  endtask

  task automatic test_single_fetch();
    instr_req_i = 1; instr_addr_i = 32'h100; mem_gnt_i = 1;
    #1;
    total++; if (instr_gnt_o !== 1'b1 || data_gnt_o !== 1'b0)
      $display("FAIL fetch_gnt got i%0h d%0h exp i1 d0", instr_gnt_o, data_gnt_o); else passed++;
    total++; if (mem_addr_o !== 32'h100) $display("FAIL fetch_addr got %h exp 00000100", mem_addr_o); else passed++;
    total++; if ({mem_be_o, mem_we_o} !== 5'b11110 || mem_wdata_o !== 32'h0)
      $display("FAIL fetch_be_we got be%h we%0h wd%h exp be f we0 wd0", mem_be_o, mem_we_o, mem_wdata_o); else passed++;
    tick();
    idle_inputs();
    mem_rvalid_i = 1; mem_rdata_i = 32'h13;
    #1;
    total++; if (busy_o !== 1'b1) $display("FAIL fetch_busy got %0h exp 1", busy_o); else passed++;
    total++; if (instr_rvalid_o !== 1'b1 || instr_rdata_o !== 32'h13 || data_rvalid_o !== 1'b0)
      $display("FAIL fetch_resp got v%0h d%h dv%0h exp v1 d00000013 dv0", instr_rvalid_o, instr_rdata_o, data_rvalid_o); else passed++;
    tick();
    mem_rvalid_i = 0;
    #1;
    total++; if (busy_o !== 1'b0) $display("FAIL fetch_idle_busy got %0h exp 0", busy_o); else passed++;
    tick();
  endtask

  task automatic test_starvation();
    logic exp_i, prev_i;
    prev_i = 0;
    for (int i = 0; i < 10; i++) begin
      exp_i = (i == 4) || (i == 9);
      instr_req_i = 1; instr_addr_i = 32'h100; data_req_i = 1; data_addr_i = 32'h200;
      mem_gnt_i = 1; mem_rvalid_i = (i > 0); mem_rdata_i = 32'(i);
      #1;
      total++; if (instr_gnt_o !== exp_i || data_gnt_o !== !exp_i)
        $display("FAIL starve_gnt[%0d] got i%0h d%0h exp i%0h d%0h", i, instr_gnt_o, data_gnt_o, exp_i, !exp_i); else passed++;
      if (i > 0) begin
        total++; if (instr_rvalid_o !== prev_i || data_rvalid_o !== !prev_i)
          $display("FAIL starve_route[%0d] got i%0h d%0h exp i%0h d%0h", i, instr_rvalid_o, data_rvalid_o, prev_i, !prev_i); else passed++;
      end
      prev_i = exp_i;
      tick();
    end
    idle_inputs();
    mem_rvalid_i = 1;
    #1;
    total++; if (instr_rvalid_o !== 1'b1) $display("FAIL starve_last_resp got %0h exp 1", instr_rvalid_o); else passed++;
    tick();
    idle_inputs();
  endtask

  task automatic test_lock();
    data_req_i = 1; data_we_i = 1; data_be_i = 4'h3; data_addr_i = 32'h200; data_wdata_i = 32'hDEADBEEF;
    for (int c = 1; c <= 4; c++) begin
      if (c >= 2) begin instr_req_i = 1; instr_addr_i = 32'h300; end
      mem_gnt_i = (c == 4);
      #1;
      total++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h200 || mem_we_o !== 1'b1 || mem_be_o !== 4'h3 || mem_wdata_o !== 32'hDEADBEEF)
        $display("FAIL lock_stable[%0d] got r%0h a%h we%0h be%h wd%h exp r1 a00000200 we1 be3 wddeadbeef",
                 c, mem_req_o, mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o); else passed++;
      total++; if (data_gnt_o !== (c == 4) || instr_gnt_o !== 1'b0)
        $display("FAIL lock_gnt[%0d] got d%0h i%0h exp d%0h i0", c, data_gnt_o, instr_gnt_o, c == 4); else passed++;
      tick();
    end
    data_req_i = 0;
    #1;
    total++; if (instr_gnt_o !== 1'b1 || mem_addr_o !== 32'h300)
      $display("FAIL lock_after_instr got g%0h a%h exp g1 a00000300", instr_gnt_o, mem_addr_o); else passed++;
    tick();
    idle_inputs();
    mem_rvalid_i = 1; mem_rdata_i = 32'hAAAA;
    #1;
    total++; if (data_rvalid_o !== 1'b1 || data_rdata_o !== 32'hAAAA || instr_rvalid_o !== 1'b0)
      $display("FAIL lock_resp_data got v%0h d%h iv%0h exp v1 d0000aaaa iv0", data_rvalid_o, data_rdata_o, instr_rvalid_o); else passed++;
    tick();
    mem_rdata_i = 32'hBBBB;
    #1;
    total++; if (instr_rvalid_o !== 1'b1 || instr_rdata_o !== 32'hBBBB)
      $display("FAIL lock_resp_instr got v%0h d%h exp v1 d0000bbbb", instr_rvalid_o, instr_rdata_o); else passed++;
    tick();
    idle_inputs();
  endtask

  task automatic test_flush();
    instr_req_i = 1; instr_addr_i = 32'h400; mem_gnt_i = 1;
    #1;
    total++; if (instr_gnt_o !== 1'b1) $display("FAIL flush_gnt0 got %0h exp 1", instr_gnt_o); else passed++;
    tick();
    instr_addr_i = 32'h404;
    #1;
    total++; if (instr_gnt_o !== 1'b1) $display("FAIL flush_gnt1 got %0h exp 1", instr_gnt_o); else passed++;
    tick();
    instr_req_i = 0; instr_flush_i = 1;
    #1;
    total++; if (instr_gnt_o !== 1'b0 || busy_o !== 1'b1)
      $display("FAIL flush_pulse got g%0h b%0h exp g0 b1", instr_gnt_o, busy_o); else passed++;
    tick();
    instr_flush_i = 0; instr_req_i = 1; instr_addr_i = 32'h500; mem_rvalid_i = 1; mem_rdata_i = 32'hAA;
    #1;
    total++; if (mem_req_o !== 1'b0 || instr_gnt_o !== 1'b0 || instr_rvalid_o !== 1'b0)
      $display("FAIL flush_drop0 got r%0h g%0h v%0h exp r0 g0 v0", mem_req_o, instr_gnt_o, instr_rvalid_o); else passed++;
    tick();
    #1;
    total++; if (mem_req_o !== 1'b1 || instr_gnt_o !== 1'b1 || instr_rvalid_o !== 1'b0)
      $display("FAIL flush_drop1 got r%0h g%0h v%0h exp r1 g1 v0", mem_req_o, instr_gnt_o, instr_rvalid_o); else passed++;
    tick();
    instr_req_i = 0; mem_rdata_i = 32'h55;
    #1;
    total++; if (instr_rvalid_o !== 1'b1 || instr_rdata_o !== 32'h55)
      $display("FAIL flush_new_resp got v%0h d%h exp v1 d00000055", instr_rvalid_o, instr_rdata_o); else passed++;
    tick();
    instr_req_i = 1; mem_rvalid_i = 0;
    tick();
    mem_rvalid_i = 1; instr_flush_i = 1; mem_rdata_i = 32'h77;
    #1;
    total++; if (instr_rvalid_o !== 1'b0 || mem_req_o !== 1'b0 || instr_gnt_o !== 1'b0)
      $display("FAIL flush_same_cycle got v%0h r%0h g%0h exp v0 r0 g0", instr_rvalid_o, mem_req_o, instr_gnt_o); else passed++;
    tick();
    idle_inputs();
    #1;
    total++; if (busy_o !== 1'b0) $display("FAIL flush_busy got %0h exp 0", busy_o); else passed++;
    tick();
  endtask

  task automatic test_full();
    instr_req_i = 1; instr_addr_i = 32'h600; mem_gnt_i = 1;
    tick();
    instr_req_i = 0; data_req_i = 1; data_addr_i = 32'h700;
    #1;
    total++; if (data_gnt_o !== 1'b1) $display("FAIL full_data_gnt got %0h exp 1", data_gnt_o); else passed++;
    tick();
    data_req_i = 0; instr_req_i = 1;
    #1;
    total++; if (mem_req_o !== 1'b0 || instr_gnt_o !== 1'b0)
      $display("FAIL full_block got r%0h g%0h exp r0 g0", mem_req_o, instr_gnt_o); else passed++;
    tick();
    mem_rvalid_i = 1; mem_rdata_i = 32'h11;
    #1;
    total++; if (mem_req_o !== 1'b0 || instr_rvalid_o !== 1'b1 || instr_rdata_o !== 32'h11)
      $display("FAIL full_pop_noissue got r%0h v%0h d%h exp r1? no: r0 v1 d00000011", mem_req_o, instr_rvalid_o, instr_rdata_o); else passed++;
    tick();
    mem_rdata_i = 32'h22; mem_err_i = 1;
    #1;
    total++; if (mem_req_o !== 1'b1 || instr_gnt_o !== 1'b1)
      $display("FAIL full_reissue got r%0h g%0h exp r1 g1", mem_req_o, instr_gnt_o); else passed++;
    total++; if (data_rvalid_o !== 1'b1 || data_rdata_o !== 32'h22 || data_err_o !== 1'b1)
      $display("FAIL full_data_resp got v%0h d%h e%0h exp v1 d00000022 e1", data_rvalid_o, data_rdata_o, data_err_o); else passed++;
    tick();
    idle_inputs();
    mem_rvalid_i = 1; mem_rdata_i = 32'h33;
    #1;
    total++; if (instr_rvalid_o !== 1'b1 || instr_rdata_o !== 32'h33 || instr_err_o !== 1'b0)
      $display("FAIL full_last_resp got v%0h d%h e%0h exp v1 d00000033 e0", instr_rvalid_o, instr_rdata_o, instr_err_o); else passed++;
    tick();
    idle_inputs();
  endtask

  task automatic test_protocol_err();
    mem_rvalid_i = 1; mem_rdata_i = 32'h99;
    #1;
    total++; if (instr_rvalid_o !== 1'b0 || data_rvalid_o !== 1'b0)
      $display("FAIL perr_no_rvalid got i%0h d%0h exp 0 0", instr_rvalid_o, data_rvalid_o); else passed++;
    tick();
    mem_rvalid_i = 0;
    #1;
    total++; if (protocol_err_o !== 1'b1) $display("FAIL perr_set got %0h exp 1", protocol_err_o); else passed++;
    tick();
    total++; if (protocol_err_o !== 1'b1) $display("FAIL perr_sticky got %0h exp 1", protocol_err_o); else passed++;
  endtask

  task automatic test_async_reset();
    instr_req_i = 1; instr_addr_i = 32'h800; mem_gnt_i = 1;
    tick();
    instr_req_i = 0; data_req_i = 1; data_addr_i = 32'h900; mem_gnt_i = 0;
    #1;
    total++; if (mem_req_o !== 1'b1 || busy_o !== 1'b1)
      $display("FAIL arst_pre got r%0h b%0h exp r1 b1", mem_req_o, busy_o); else passed++;
    #1 rst = 1;
    #1;
    total++; if ({mem_req_o, data_gnt_o, busy_o, protocol_err_o} !== 4'b0 || mem_addr_o !== 32'h0 || mem_be_o !== 4'h0)
      $display("FAIL arst_outputs got r%0h g%0h b%0h p%0h a%h be%h exp all 0",
               mem_req_o, data_gnt_o, busy_o, protocol_err_o, mem_addr_o, mem_be_o); else passed++;
    idle_inputs();
    #2 rst = 0;
    tick();
    mem_rvalid_i = 1;
    #1;
    total++; if (instr_rvalid_o !== 1'b0 || busy_o !== 1'b0)
      $display("FAIL arst_late_resp got v%0h b%0h exp v0 b0", instr_rvalid_o, busy_o); else passed++;
    tick();
    mem_rvalid_i = 0;
    total++; if (protocol_err_o !== 1'b1) $display("FAIL arst_perr got %0h exp 1", protocol_err_o); else passed++;
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    #12;
    test_reset();
    test_single_fetch();
    test_starvation();
    test_lock();
    test_flush();
    test_full();
    test_protocol_err();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got running exp finished");
    $fatal(1);
  end

endmodule
